// File: rtl/sc_fir_pkg.sv
// Shared types and defaults for the stochastic-computing FIR sequencer.
package sc_fir_pkg;

    localparam int unsigned DefN     = 12;
    localparam int unsigned DefOrder = 18;
    localparam int unsigned DefDpLat = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned stream_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Counts ones on the qualified output bitstream; result saturates a full-length count to 2^N-1.
module sc_ones_counter #(
    parameter int unsigned N = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] result_o
);

    logic [N:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + (N+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A run counts at most 2^N ones, so the top bit alone marks the saturating case.
    assign result_o = count_q[N] ? {N{1'b1}} : count_q[N-1:0];

endmodule

// File: rtl/sc_fir_sequencer.sv
// Sequences one SC FIR evaluation per sample: tap shift, RNG reseed, 2^N-cycle stream, ones count.
module sc_fir_sequencer
    import sc_fir_pkg::*;
#(
    parameter int unsigned N      = DefN,
    parameter int unsigned ORDER  = DefOrder,
    parameter int unsigned DP_LAT = DefDpLat
) (
    input  logic             clock_d,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    output logic             in_ready,
    output logic [ORDER*N-1:0] taps,
    output logic             seed_load,
    output logic             stream_en,
    input  logic             sc_bit,
    output logic [N-1:0]     out,
    output logic             done,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned StreamLen = stream_len(N);
    localparam int unsigned DrainLast = (DP_LAT > 0) ? DP_LAT - 1 : 0;

    state_e              state_q, state_d;
    logic [N-1:0]        sample_q;
    logic [ORDER*N-1:0]  taps_q, taps_d;
    logic [N-1:0]        run_cnt_q, run_cnt_d;
    logic [N-1:0]        out_q;
    logic                done_q;
    logic                overrun_q;
    logic                ones_clr;
    logic                cnt_en;
    logic [N-1:0]        ones_result;

    always_comb begin
        state_d   = state_q;
        taps_d    = taps_q;
        run_cnt_d = run_cnt_q;
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        seed_load = 1'b0;
        stream_en = 1'b0;
        ones_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                seed_load = 1'b1;
                ones_clr  = 1'b1;
                run_cnt_d = '0;
                for (int k = 1; k < ORDER; k++) begin
                    taps_d[k*N +: N] = taps_q[(k-1)*N +: N];
                end
                taps_d[N-1:0] = sample_q;
                state_d = StRun;
            end
            StRun: begin
                stream_en = 1'b1;
                run_cnt_d = run_cnt_q + N'(1);
                if (run_cnt_q == N'(StreamLen - 1)) begin
                    run_cnt_d = '0;
                    state_d   = (DP_LAT == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                // Run counter is reused to time the datapath drain window.
                run_cnt_d = run_cnt_q + N'(1);
                if (run_cnt_q == N'(DrainLast)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_d or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sample_q  <= '0;
            taps_q    <= '0;
            run_cnt_q <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            taps_q    <= taps_d;
            run_cnt_q <= run_cnt_d;
            done_q    <= (state_q == StDone);
            if (state_q == StIdle && in_valid) begin
                sample_q <= in;
            end
            // The final qualified bit is counted on the edge entering StDone.
            if (state_q == StDone) begin
                out_q <= ones_result;
            end
            if (in_valid && !in_ready) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    generate
        if (DP_LAT == 0) begin : g_no_pipe
            assign cnt_en = stream_en;
        end else begin : g_pipe
            logic [DP_LAT-1:0] pipe_q;
            always_ff @(posedge clock_d or posedge reset) begin
                if (reset) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= stream_en;
                    for (int i = 1; i < DP_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign cnt_en = pipe_q[DP_LAT-1];
        end
    endgenerate

    sc_ones_counter #(
        .N(N)
    ) u_ones_counter (
        .clk_i    (clock_d),
        .rst_i    (reset),
        .clr_i    (ones_clr),
        .en_i     (cnt_en & sc_bit),
        .result_o (ones_result)
    );

    assign taps    = taps_q;
    assign out     = out_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Directed self-checking bench: default-size sequencer plus a small N=5, DP_LAT=0 instance.
module tb_sc_fir_sequencer;

    localparam int unsigned N     = 12;
    localparam int unsigned ORDER = 18;
    localparam int unsigned SN    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 in_valid_m, sc_bit_m, clr_overrun_m;
    logic [N-1:0]         in_m;
    logic                 in_ready_m, seed_load_m, stream_en_m, done_m, busy_m, overrun_m;
    logic [ORDER*N-1:0]   taps_m;
    logic [N-1:0]         out_m;

    logic                 in_valid_s, sc_bit_s, clr_overrun_s;
    logic [SN-1:0]        in_s;
    logic                 in_ready_s, seed_load_s, stream_en_s, done_s, busy_s, overrun_s;
    logic [ORDER*SN-1:0]  taps_s;
    logic [SN-1:0]        out_s;

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    sc_fir_sequencer #(
        .N(N), .ORDER(ORDER), .DP_LAT(2)
    ) dut (
        .clock_d     (clk),
        .reset       (reset),
        .in_valid    (in_valid_m),
        .in          (in_m),
        .in_ready    (in_ready_m),
        .taps        (taps_m),
        .seed_load   (seed_load_m),
        .stream_en   (stream_en_m),
        .sc_bit      (sc_bit_m),
        .out         (out_m),
        .done        (done_m),
        .busy        (busy_m),
        .overrun     (overrun_m),
        .clr_overrun (clr_overrun_m)
    );

    sc_fir_sequencer #(
        .N(SN), .ORDER(ORDER), .DP_LAT(0)
    ) dut_s (
        .clock_d     (clk),
        .reset       (reset),
        .in_valid    (in_valid_s),
        .in          (in_s),
        .in_ready    (in_ready_s),
        .taps        (taps_s),
        .seed_load   (seed_load_s),
        .stream_en   (stream_en_s),
        .sc_bit      (sc_bit_s),
        .out         (out_s),
        .done        (done_s),
        .busy        (busy_s),
        .overrun     (overrun_s),
        .clr_overrun (clr_overrun_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] tap_m(input int k);
        return taps_m[k*N +: N];
    endfunction

    function automatic logic [SN-1:0] tap_s(input int k);
        return taps_s[k*SN +: SN];
    endfunction

    // mode 0: sc_bit always 1; mode 1: sc_bit=1 only in un-delayed stream window;
    // mode 2: 1,0,1,0 aligned to the delayed window, 1 outside it.
    task automatic run_main(input logic [N-1:0] sample, input int mode,
                            input logic [N-1:0] exp_out, input bit ovr, input bit rst_mid);
        logic [N-1:0] prev0;
        int waited, seeds, streams, first, last, both, dones;
        prev0   = tap_m(0);
        waited  = 0;
        seeds   = 0;
        streams = 0;
        first   = -1;
        last    = -1;
        both    = 0;
        dones   = 0;
        while (!in_ready_m && waited < 10000) begin
            step();
            waited++;
        end
        if (!in_ready_m) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        in_m       = sample;
        in_valid_m = 1'b1;
        step();
        in_valid_m = 1'b0;
        for (int c = 0; c <= 4100; c++) begin
            case (mode)
                0:       sc_bit_m = 1'b1;
                1:       sc_bit_m = (c >= 1 && c <= 4096);
                default: sc_bit_m = (c < 3 || c > 4098) ? 1'b1 : ((c - 3) % 2 == 0);
            endcase
            if (c == 0) check("seed_load_c0", seed_load_m, 1);
            if (seed_load_m) seeds++;
            if (stream_en_m) begin
                streams++;
                if (first < 0) first = c;
                last = c;
            end
            if (seed_load_m && stream_en_m) both++;
            if (c < 4100 && done_m) dones++;
            if (ovr) begin
                if (c == 100) begin
                    in_m       = 7;
                    in_valid_m = 1'b1;
                    check("in_ready_run", in_ready_m, 0);
                end
                if (c == 101) begin
                    in_valid_m = 1'b0;
                    check("overrun_set", overrun_m, 1);
                    check("taps_kept", tap_m(0), sample);
                end
                if (c == 200) begin
                    in_valid_m    = 1'b1;
                    clr_overrun_m = 1'b1;
                end
                if (c == 201) begin
                    in_valid_m    = 1'b0;
                    clr_overrun_m = 1'b0;
                    check("overrun_set_wins", overrun_m, 1);
                end
                if (c == 300) clr_overrun_m = 1'b1;
                if (c == 301) begin
                    clr_overrun_m = 1'b0;
                    check("overrun_clr", overrun_m, 0);
                end
            end
            if (rst_mid && c == 1000) begin
                reset = 1'b1;
                #1;
                check("rst_mid_stream_en", stream_en_m, 0);
                check("rst_mid_busy", busy_m, 0);
                check("rst_mid_taps", (taps_m == '0), 1);
                check("rst_mid_out", out_m, 0);
                step();
                step();
                reset    = 1'b0;
                sc_bit_m = 1'b0;
                dones    = 0;
                for (int i = 0; i < 200; i++) begin
                    step();
                    if (done_m) dones++;
                end
                check("rst_mid_no_done", dones, 0);
                check("rst_mid_ready", in_ready_m, 1);
                return;
            end
            if (c < 4100) step();
        end
        check("seed_count", seeds, 1);
        check("stream_count", streams, 4096);
        check("stream_first", first, 1);
        check("stream_contiguous", last - first + 1, 4096);
        check("seed_stream_overlap", both, 0);
        check("done_early", dones, 0);
        check("done_latency", done_m, 1);
        check("out_value", out_m, exp_out);
        check("tap0", tap_m(0), sample);
        check("tap1", tap_m(1), prev0);
        check("busy_at_done", busy_m, 0);
        sc_bit_m = 1'b0;
        step();
        check("done_pulse", done_m, 0);
        check("out_held", out_m, exp_out);
    endtask

    task automatic run_small();
        int waited, lat, bad;
        bad = 0;
        for (int s = 1; s <= 19; s++) begin
            waited = 0;
            while (!in_ready_s && waited < 200) begin
                step();
                waited++;
            end
            if (!in_ready_s) begin
                check("small_ready_timeout", 64'd0, 64'd1);
                return;
            end
            in_s       = SN'(s);
            in_valid_s = 1'b1;
            step();
            in_valid_s = 1'b0;
            lat        = 0;
            while (!done_s && lat < 200) begin
                step();
                lat++;
            end
            if (lat != 34) bad++;
        end
        check("small_latency_bad", bad, 0);
        check("small_out_sat", out_s, 31);
        check("small_overrun", overrun_s, 0);
        for (int k = 0; k < ORDER; k++) begin
            check($sformatf("small_tap%0d", k), tap_s(k), 64'(19 - k));
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid_m    = 1'b0;
        in_m          = '0;
        sc_bit_m      = 1'b0;
        clr_overrun_m = 1'b0;
        in_valid_s    = 1'b0;
        in_s          = '0;
        sc_bit_s      = 1'b1;
        clr_overrun_s = 1'b0;
        step();
        step();
        step();
        reset = 1'b0;
        check("rst_out", out_m, 0);
        check("rst_done", done_m, 0);
        check("rst_in_ready", in_ready_m, 1);
        check("rst_busy", busy_m, 0);
        check("rst_taps", (taps_m == '0), 1);
        check("rst_stream_en", stream_en_m, 0);
        check("rst_seed_load", seed_load_m, 0);
        check("rst_overrun", overrun_m, 0);

        run_small();

        run_main(12'h123, 0, 12'd4095, 1'b0, 1'b0);
        run_main(12'h456, 1, 12'd4094, 1'b0, 1'b0);
        run_main(12'h789, 2, 12'd2048, 1'b0, 1'b0);
        run_main(12'hABC, 0, 12'd4095, 1'b1, 1'b0);
        run_main(12'hDEF, 0, 12'd0,    1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
